// File: rtl/hdlc_rx_channel.sv
// hdlc_rx_channel: HDLC serial rx front end (flag/abort detect, zero removal, byte assembly); define RX_IDLE_DETECT_EN for idle detection
module hdlc_rx_channel #(
  parameter int MIN_FRAME_BYTES = 4,
  parameter int IDLE_ONES = 15
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       RxEN,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic       Rx_NewByte,
  output logic [7:0] Rx_Data,
  output logic       Rx_StartZeroDetect,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic       Rx_Idle
);
  typedef enum logic [1:0] {IDLE, FLAG, FRAME} state_t;
  state_t state, nxt;
  logic rxd, flag_m, abort_m, stuff_m, stuff_in, idle_rise, abort_ev, take, close, cut, eof_d, err_d;
  logic [7:0] win, tag, acc, byte_cnt;
  logic [2:0] bit_cnt;
`ifdef RX_IDLE_DETECT_EN
  localparam int IW = $clog2(IDLE_ONES + 1);
  logic [IW-1:0] ones;
  logic idle_p;
  always_ff @(posedge Clk)
    if (Rst) begin
      ones <= '0;
      idle_p <= 1'b0;
    end else begin
      ones <= !rxd ? '0 : (Rx_Idle ? ones : ones + 1'b1);
      idle_p <= Rx_Idle;
    end
  assign Rx_Idle = ones == IW'(IDLE_ONES);
  assign idle_rise = Rx_Idle & ~idle_p;
`else
  logic unused_idle;
  assign unused_idle = ^IDLE_ONES;
  assign Rx_Idle = 1'b0;
  assign idle_rise = 1'b0;
`endif
  always_comb begin
    flag_m = win == 8'h7E;
    abort_m = win == 8'hFE;
    stuff_m = win[7:1] == 7'b0111110;
    stuff_in = {rxd, win[7:2]} == 7'b0111110;
    abort_ev = abort_m | (idle_rise & (state == FRAME));
    take = tag[0] & ~flag_m & ~abort_ev;
    nxt = state;
    close = 1'b0;
    cut = 1'b0;
    if (!RxEN) nxt = IDLE;
    else if (abort_ev) begin
      nxt = IDLE;
      cut = state == FRAME;
    end else if (flag_m) begin
      nxt = FLAG;
      close = state == FRAME;
    end else if (take && state == FLAG) nxt = FRAME;
  end
  always_ff @(posedge Clk)
    if (Rst) begin
      state <= IDLE;
      rxd <= 1'b1;
      win <= '1;
      tag <= '0;
      acc <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      eof_d <= 1'b0;
      err_d <= 1'b0;
      Rx_FlagDetect <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      Rx_StartZeroDetect <= 1'b0;
      Rx_ValidFrame <= 1'b0;
      Rx_NewByte <= 1'b0;
      Rx_Data <= 8'h00;
      Rx_EoF <= 1'b0;
      Rx_FrameError <= 1'b0;
    end else begin
      state <= nxt;
      rxd <= Rx;
      win <= {rxd, win[7:1]};
      tag <= (flag_m | abort_ev) ? {~stuff_in, 7'd0} : {~stuff_in, tag[7:1]};
      Rx_FlagDetect <= RxEN & flag_m;
      Rx_AbortDetect <= RxEN & abort_ev;
      Rx_StartZeroDetect <= RxEN & stuff_m;
      Rx_ValidFrame <= nxt == FRAME;
      Rx_NewByte <= take & (nxt == FRAME) & (bit_cnt == 3'd7);
      eof_d <= close | cut;
      err_d <= close & ((bit_cnt != 3'd0) | (byte_cnt < 8'(MIN_FRAME_BYTES)));
      Rx_EoF <= eof_d & RxEN;
      Rx_FrameError <= err_d & RxEN;
      if (nxt != FRAME) begin
        bit_cnt <= '0;
        byte_cnt <= '0;
      end else if (take) begin
        acc <= {win[0], acc[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          Rx_Data <= {win[0], acc[7:1]};
          byte_cnt <= byte_cnt + {7'd0, byte_cnt != 8'hFF};
        end
      end
    end
endmodule
